// File: rtl/axm_err_sweep_ctrl_if.sv
// Bus between the approximate-multiplier sweep controller and its surroundings:
// multiplier operands/product, sweep control and the accumulated statistics.
interface axm_err_sweep_ctrl_if #(
    parameter int W = 4
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_y;
    logic [2*W:0]     err_cnt;
    logic [4*W-1:0]   sum_ed;
    logic [2*W-1:0]   max_ed;
    logic [W-1:0]     fail_a;
    logic [W-1:0]     fail_b;
    logic [2*W-1:0]   fail_y;
    logic             fail_vld;

    modport master (
        output start, abort, mul_y,
        input  busy, done, mul_a, mul_b, err_cnt, sum_ed, max_ed,
               fail_a, fail_b, fail_y, fail_vld
    );

    modport slave (
        input  start, abort, mul_y,
        output busy, done, mul_a, mul_b, err_cnt, sum_ed, max_ed,
               fail_a, fail_b, fail_y, fail_vld
    );
endinterface

// File: rtl/axm_err_sweep_ctrl.sv
// Exhaustive error sweep of an external combinational W x W approximate multiplier.
// Optional first-failure capture is built when AXM_SWEEP_FAILCAP_EN is defined.
module axm_err_sweep_ctrl #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axm_err_sweep_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [W-1:0]   OP_MAX      = {W{1'b1}};
    localparam logic [W-1:0]   OP_ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W:0]   CNT_ONE     = {{(2*W){1'b0}}, 1'b1};
    localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state_r;
    logic [3:0]       settle_cnt_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             busy_r;
    logic             done_r;
    logic [2*W:0]     err_cnt_r;
    logic [4*W-1:0]   sum_ed_r;
    logic [2*W-1:0]   max_ed_r;

    logic [2*W-1:0]   prod_s;
    logic [2*W-1:0]   ed_s;
    logic             err_s;

    // Exact product and error distance of the pair currently on the multiplier
    always_comb begin
        prod_s = {{W{1'b0}}, a_r} * {{W{1'b0}}, b_r};
        if (bus.mul_y >= prod_s) begin
            ed_s = bus.mul_y - prod_s;
        end else begin
            ed_s = prod_s - bus.mul_y;
        end
        err_s = (ed_s != {(2*W){1'b0}});
    end

    // Sweep sequencer: state, operands, flags and statistics accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            settle_cnt_r <= 4'd0;
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_cnt_r    <= {(2*W+1){1'b0}};
            sum_ed_r     <= {(4*W){1'b0}};
            max_ed_r     <= {(2*W){1'b0}};
        end else if (bus.abort) begin
            // Statistics freeze; a SAMPLE in this cycle is dropped
            state_r      <= IDLE;
            settle_cnt_r <= 4'd0;
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r      <= DRIVE;
                        settle_cnt_r <= 4'd0;
                        a_r          <= {W{1'b0}};
                        b_r          <= {W{1'b0}};
                        busy_r       <= 1'b1;
                        err_cnt_r    <= {(2*W+1){1'b0}};
                        sum_ed_r     <= {(4*W){1'b0}};
                        max_ed_r     <= {(2*W){1'b0}};
                    end
                end
                DRIVE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_r <= 4'd0;
                        state_r      <= SAMPLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                    end
                end
                SAMPLE: begin
                    if (err_s) begin
                        err_cnt_r <= err_cnt_r + CNT_ONE;
                        sum_ed_r  <= sum_ed_r + {{(2*W){1'b0}}, ed_s};
                        if (ed_s > max_ed_r) begin
                            max_ed_r <= ed_s;
                        end
                    end
                    b_r <= b_r + OP_ONE;
                    if (b_r == OP_MAX) begin
                        a_r <= a_r + OP_ONE;
                    end
                    if ((a_r == OP_MAX) && (b_r == OP_MAX)) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRIVE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    a_r     <= {W{1'b0}};
                    b_r     <= {W{1'b0}};
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mul_a   = a_r;
    assign bus.mul_b   = b_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err_cnt = err_cnt_r;
    assign bus.sum_ed  = sum_ed_r;
    assign bus.max_ed  = max_ed_r;

`ifdef AXM_SWEEP_FAILCAP_EN
    logic [W-1:0]     fail_a_r;
    logic [W-1:0]     fail_b_r;
    logic [2*W-1:0]   fail_y_r;
    logic             fail_vld_r;

    // First-failure capture, cleared on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a_r   <= {W{1'b0}};
            fail_b_r   <= {W{1'b0}};
            fail_y_r   <= {(2*W){1'b0}};
            fail_vld_r <= 1'b0;
        end else if (!bus.abort) begin
            if ((state_r == IDLE) && bus.start) begin
                fail_a_r   <= {W{1'b0}};
                fail_b_r   <= {W{1'b0}};
                fail_y_r   <= {(2*W){1'b0}};
                fail_vld_r <= 1'b0;
            end else if ((state_r == SAMPLE) && err_s && !fail_vld_r) begin
                fail_a_r   <= a_r;
                fail_b_r   <= b_r;
                fail_y_r   <= bus.mul_y;
                fail_vld_r <= 1'b1;
            end
        end
    end

    assign bus.fail_a   = fail_a_r;
    assign bus.fail_b   = fail_b_r;
    assign bus.fail_y   = fail_y_r;
    assign bus.fail_vld = fail_vld_r;
`else
    assign bus.fail_a   = {W{1'b0}};
    assign bus.fail_b   = {W{1'b0}};
    assign bus.fail_y   = {(2*W){1'b0}};
    assign bus.fail_vld = 1'b0;
`endif
endmodule

// File: tb/tb_axm_err_sweep_ctrl.sv
// Bench for axm_err_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) sweep a
// table-driven multiplier; results are checked against a pair-by-pair reference.
module tb_axm_err_sweep_ctrl;
    localparam int W  = 4;
    localparam int NP = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axm_err_sweep_ctrl_if #(.W(W)) bus1 ();
    axm_err_sweep_ctrl_if #(.W(W)) bus3 ();

    axm_err_sweep_ctrl #(.W(W), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    axm_err_sweep_ctrl #(.W(W), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    // Multiplier under test: product looked up from a table indexed by {a,b}
    logic [7:0] lut [NP];
    always_comb bus1.mul_y = lut[{bus1.mul_a, bus1.mul_b}];
    always_comb bus3.mul_y = lut[{bus3.mul_a, bus3.mul_b}];

    int passed = 0;
    int total  = 0;

    logic [8:0]  exp_err;
    logic [15:0] exp_sum;
    logic [7:0]  exp_max;
    logic [3:0]  exp_fa;
    logic [3:0]  exp_fb;
    logic [7:0]  exp_fy;
    logic        exp_fv;

    int lat, dcnt, busy0;

    task automatic fill_lut(input int mode);
        int p;
        for (int i = 0; i < NP; i++) begin
            p = (i / 16) * (i % 16);
            case (mode)
                0: lut[i] = 8'(p);
                1: lut[i] = 8'(p) & 8'hFE;
                2: lut[i] = 8'd0;
                default: lut[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(p);
            endcase
        end
    endtask

    // Reference: statistics over the first npairs pairs in sweep order
    task automatic model_stats(input int npairs);
        int a, b, p, y, ed, ec, se, mx, fa, fb, fy, fv;
        ec = 0; se = 0; mx = 0; fa = 0; fb = 0; fy = 0; fv = 0;
        for (int i = 0; i < npairs; i++) begin
            a = i / 16;
            b = i % 16;
            p = a * b;
            y = int'(lut[i]);
            ed = (y > p) ? (y - p) : (p - y);
            if (ed != 0) begin
                ec += 1;
                se += ed;
                if (ed > mx) mx = ed;
                if (fv == 0) begin
                    fv = 1; fa = a; fb = b; fy = y;
                end
            end
        end
`ifndef AXM_SWEEP_FAILCAP_EN
        fv = 0; fa = 0; fb = 0; fy = 0;
`endif
        exp_err = 9'(ec);
        exp_sum = 16'(se);
        exp_max = 8'(mx);
        exp_fa  = 4'(fa);
        exp_fb  = 4'(fb);
        exp_fy  = 8'(fy);
        exp_fv  = (fv != 0);
    endtask

    // Starts one sweep and records done latency / pulse width; optional stray start at restart_at
    task automatic run_sweep(input bit use3, input int restart_at);
        logic d;
        lat = 0; dcnt = 0;
        @(negedge clk);
        if (use3) bus3.start = 1'b1; else bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0; bus3.start = 1'b0;
        busy0 = use3 ? int'(bus3.busy) : int'(bus1.busy);
        for (int j = 1; j <= 2000; j++) begin
            @(negedge clk);
            if (use3) bus3.start = (j == restart_at); else bus1.start = (j == restart_at);
            d = use3 ? bus3.done : bus1.done;
            if (d) begin
                dcnt++;
                if (lat == 0) lat = j;
            end
            if ((lat != 0) && (j >= lat + 3)) break;
        end
        bus1.start = 1'b0; bus3.start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus1.busy, bus1.done, bus1.mul_a, bus1.mul_b, bus1.fail_vld} !== 11'd0) begin
            $display("FAIL reset_flags1 got %b want 0", {bus1.busy, bus1.done, bus1.mul_a, bus1.mul_b, bus1.fail_vld});
        end else passed++;
        total++;
        if ({bus1.err_cnt, bus1.sum_ed, bus1.max_ed} !== 33'd0) begin
            $display("FAIL reset_stats1 got %h want 0", {bus1.err_cnt, bus1.sum_ed, bus1.max_ed});
        end else passed++;
        total++;
        if ({bus3.busy, bus3.done, bus3.mul_a, bus3.mul_b, bus3.err_cnt, bus3.sum_ed, bus3.max_ed} !== 43'd0) begin
            $display("FAIL reset_all3 got %h want 0", {bus3.busy, bus3.done, bus3.mul_a, bus3.mul_b, bus3.err_cnt, bus3.sum_ed, bus3.max_ed});
        end else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exact();
        fill_lut(0);
        run_sweep(1'b0, 0);
        total++;
        if (lat !== 512) $display("FAIL exact_latency got %0d want 512", lat); else passed++;
        total++;
        if (dcnt !== 1) $display("FAIL exact_done_width got %0d want 1", dcnt); else passed++;
        total++;
        if (busy0 !== 1) $display("FAIL exact_busy_rise got %0d want 1", busy0); else passed++;
        total++;
        if ({bus1.err_cnt, bus1.sum_ed, bus1.max_ed, bus1.fail_vld} !== 34'd0)
            $display("FAIL exact_stats got %h want 0", {bus1.err_cnt, bus1.sum_ed, bus1.max_ed, bus1.fail_vld});
        else passed++;
    endtask

    task automatic test_bit0();
        logic [3:0] fa, fb;
        logic [7:0] fy;
        logic fv;
        fill_lut(1);
        run_sweep(1'b0, 0);
`ifdef AXM_SWEEP_FAILCAP_EN
        fa = 4'd1; fb = 4'd1; fy = 8'd0; fv = 1'b1;
`else
        fa = 4'd0; fb = 4'd0; fy = 8'd0; fv = 1'b0;
`endif
        total++;
        if (bus1.err_cnt !== 9'd64) $display("FAIL bit0_err_cnt got %0d want 64", bus1.err_cnt); else passed++;
        total++;
        if (bus1.sum_ed !== 16'd64) $display("FAIL bit0_sum_ed got %0d want 64", bus1.sum_ed); else passed++;
        total++;
        if (bus1.max_ed !== 8'd1) $display("FAIL bit0_max_ed got %0d want 1", bus1.max_ed); else passed++;
        total++;
        if ({bus1.fail_vld, bus1.fail_a, bus1.fail_b, bus1.fail_y} !== {fv, fa, fb, fy})
            $display("FAIL bit0_failcap got %h want %h", {bus1.fail_vld, bus1.fail_a, bus1.fail_b, bus1.fail_y}, {fv, fa, fb, fy});
        else passed++;
    endtask

    task automatic test_zero();
        logic [3:0] fa, fb;
        logic fv;
        fill_lut(2);
        run_sweep(1'b0, 0);
`ifdef AXM_SWEEP_FAILCAP_EN
        fa = 4'd1; fb = 4'd1; fv = 1'b1;
`else
        fa = 4'd0; fb = 4'd0; fv = 1'b0;
`endif
        total++;
        if (bus1.err_cnt !== 9'd225) $display("FAIL zero_err_cnt got %0d want 225", bus1.err_cnt); else passed++;
        total++;
        if (bus1.sum_ed !== 16'd14400) $display("FAIL zero_sum_ed got %0d want 14400", bus1.sum_ed); else passed++;
        total++;
        if (bus1.max_ed !== 8'd225) $display("FAIL zero_max_ed got %0d want 225", bus1.max_ed); else passed++;
        total++;
        if ({bus1.fail_vld, bus1.fail_a, bus1.fail_b} !== {fv, fa, fb})
            $display("FAIL zero_failcap got %h want %h", {bus1.fail_vld, bus1.fail_a, bus1.fail_b}, {fv, fa, fb});
        else passed++;
    endtask

    task automatic test_random_restart_ignored(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            fill_lut(3);
            model_stats(NP);
            run_sweep(1'b0, 100);
            total++;
            if ((lat !== 512) || (dcnt !== 1)) $display("FAIL restart_done got lat=%0d width=%0d want 512/1", lat, dcnt); else passed++;
            total++;
            if ({bus1.err_cnt, bus1.sum_ed, bus1.max_ed} !== {exp_err, exp_sum, exp_max})
                $display("FAIL random_stats got %0d/%0d/%0d want %0d/%0d/%0d", bus1.err_cnt, bus1.sum_ed, bus1.max_ed, exp_err, exp_sum, exp_max);
            else passed++;
            total++;
            if ({bus1.fail_vld, bus1.fail_a, bus1.fail_b, bus1.fail_y} !== {exp_fv, exp_fa, exp_fb, exp_fy})
                $display("FAIL random_failcap got %h want %h", {bus1.fail_vld, bus1.fail_a, bus1.fail_b, bus1.fail_y}, {exp_fv, exp_fa, exp_fb, exp_fy});
            else passed++;
        end
    endtask

    // Uses the table left by the previous random sweep on the SETTLE=1 instance
    task automatic test_settle3();
        model_stats(NP);
        run_sweep(1'b1, 0);
        total++;
        if ((lat !== 1024) || (dcnt !== 1)) $display("FAIL settle3_done got lat=%0d width=%0d want 1024/1", lat, dcnt); else passed++;
        total++;
        if ({bus3.err_cnt, bus3.sum_ed, bus3.max_ed} !== {exp_err, exp_sum, exp_max})
            $display("FAIL settle3_stats got %0d/%0d/%0d want %0d/%0d/%0d", bus3.err_cnt, bus3.sum_ed, bus3.max_ed, exp_err, exp_sum, exp_max);
        else passed++;
        total++;
        if ({bus3.err_cnt, bus3.sum_ed, bus3.max_ed} !== {bus1.err_cnt, bus1.sum_ed, bus1.max_ed})
            $display("FAIL settle3_vs_settle1 got %h want %h", {bus3.err_cnt, bus3.sum_ed, bus3.max_ed}, {bus1.err_cnt, bus1.sum_ed, bus1.max_ed});
        else passed++;
    endtask

    // Abort lands on the SAMPLE cycle of pair 100, whose accumulation must be dropped
    task automatic test_abort();
        logic [32:0] frozen;
        int ndone;
        fill_lut(3);
        lut[100] = 8'd0;
        model_stats(100);
        @(negedge clk); bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0;
        repeat (201) @(negedge clk);
        bus1.abort = 1'b1;
        @(negedge clk); bus1.abort = 1'b0;
        total++;
        if ({bus1.busy, bus1.done, bus1.mul_a, bus1.mul_b} !== 10'd0)
            $display("FAIL abort_idle got %b want 0", {bus1.busy, bus1.done, bus1.mul_a, bus1.mul_b});
        else passed++;
        total++;
        if ({bus1.err_cnt, bus1.sum_ed, bus1.max_ed} !== {exp_err, exp_sum, exp_max})
            $display("FAIL abort_partial got %0d/%0d/%0d want %0d/%0d/%0d", bus1.err_cnt, bus1.sum_ed, bus1.max_ed, exp_err, exp_sum, exp_max);
        else passed++;
        frozen = {exp_err, exp_sum, exp_max};
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus1.done) ndone++;
        end
        total++;
        if (ndone !== 0) $display("FAIL abort_no_done got %0d pulses want 0", ndone); else passed++;
        total++;
        if ({bus1.err_cnt, bus1.sum_ed, bus1.max_ed} !== frozen)
            $display("FAIL abort_frozen got %h want %h", {bus1.err_cnt, bus1.sum_ed, bus1.max_ed}, frozen);
        else passed++;
        bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0;
        total++;
        if ({bus1.busy, bus1.mul_a, bus1.mul_b, bus1.err_cnt, bus1.sum_ed, bus1.max_ed} !== {1'b1, 41'd0})
            $display("FAIL abort_restart got %h want %h", {bus1.busy, bus1.mul_a, bus1.mul_b, bus1.err_cnt, bus1.sum_ed, bus1.max_ed}, {1'b1, 41'd0});
        else passed++;
        bus1.abort = 1'b1;
        @(negedge clk); bus1.abort = 1'b0;
    endtask

    task automatic test_abort_start_idle();
        int nbusy;
        @(negedge clk); bus1.start = 1'b1; bus1.abort = 1'b1;
        @(negedge clk); bus1.start = 1'b0; bus1.abort = 1'b0;
        nbusy = 0;
        repeat (6) begin
            if (bus1.busy || (bus1.mul_b !== 4'd0)) nbusy++;
            @(negedge clk);
        end
        total++;
        if (nbusy !== 0) $display("FAIL abort_beats_start got %0d active cycles want 0", nbusy); else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        fill_lut(2);
        @(negedge clk); bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus1.busy, bus1.done, bus1.mul_a, bus1.mul_b, bus1.fail_vld} !== 11'd0)
            $display("FAIL rst_mid_flags got %b want 0", {bus1.busy, bus1.done, bus1.mul_a, bus1.mul_b, bus1.fail_vld});
        else passed++;
        total++;
        if ({bus1.err_cnt, bus1.sum_ed, bus1.max_ed} !== 33'd0)
            $display("FAIL rst_mid_stats got %h want 0", {bus1.err_cnt, bus1.sum_ed, bus1.max_ed});
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus1.busy, bus1.done, bus1.mul_b} !== 6'd0)
            $display("FAIL rst_mid_stays_idle got %b want 0", {bus1.busy, bus1.done, bus1.mul_b});
        else passed++;
    endtask

    initial begin
        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus3.start = 1'b0; bus3.abort = 1'b0;
        fill_lut(0);
        test_reset();
        test_exact();
        test_bit0();
        test_zero();
        test_random_restart_ignored(2);
        test_settle3();
        test_abort();
        test_abort_start_idle();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
